kitchen_timer_ctrl: RTL and testbench

- Sequencing controller for the board's countdown-timer/alarm function.
- Turns push-button presses (PSW) and the BCD rotary-switch preset (RSW) into a state machine that loads, runs, pauses and clears a M:SS BCD countdown.
- Raises the alarm on LED and BZ when the count reaches 0:00.
- Outputs raw BCD digits; the existing 7-seg decoders render them as 0M:SS on SEG_B/SEG_C/SEG_D.

---
 rtl/kitchen_timer_ctrl.sv | 232 +++++++++++++++++++++++
 tb/tb_kitchen_timer_ctrl.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/kitchen_timer_ctrl.sv
// kitchen_timer_ctrl
// Sequencing controller for a M:SS BCD countdown timer with alarm.
// The push buttons load a preset from the rotary switch, start, pause and
// clear the count. The alarm lamps and buzzer sound when the count reaches 0:00.
//
// Ports:
//   CLOCK   in   1  system clock, all state on the rising edge
//   RESET   in   1  asynchronous active-high reset
//   PSW     in   4  buttons (async): [0] start/pause, [1] load, [2] stop, [3] clear
//   RSW     in   4  BCD preset minutes (10-15 clamp to 9)
//   DIG_M   out  4  minutes digit
//   DIG_ST  out  4  tens-of-seconds digit
//   DIG_S   out  4  seconds digit
//   LED     out  8  status lamps
//   BZ      out  1  buzzer drive
//   STATE   out  2  0 IDLE, 1 RUN, 2 PAUSE, 3 ALARM
module kitchen_timer_ctrl #(
  parameter int TICK_DIV  = 1000,
  parameter int BZ_DIV    = 1,
  parameter int ALARM_SEC = 30
) (
  input  logic       CLOCK,
  input  logic       RESET,
  input  logic [3:0] PSW,
  input  logic [3:0] RSW,
  output logic [3:0] DIG_M,
  output logic [3:0] DIG_ST,
  output logic [3:0] DIG_S,
  output logic [7:0] LED,
  output logic       BZ,
  output logic [1:0] STATE
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int BW = (BZ_DIV > 1) ? $clog2(BZ_DIV) : 1;
  localparam int AW = (ALARM_SEC > 1) ? $clog2(ALARM_SEC) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] HALF      = PW'(TICK_DIV / 2);
  localparam logic [BW-1:0] BZ_MAX    = BW'(BZ_DIV - 1);
  localparam logic [AW-1:0] ALARM_MAX = AW'(ALARM_SEC - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_ALARM = 2'd3
  } state_t;

  state_t        state_reg, state_next;
  logic [3:0]    psw_s1_reg, psw_s2_reg, psw_prev_reg, press_reg;
  logic [3:0]    dig_m_reg, dig_st_reg, dig_s_reg;
  logic [3:0]    dig_m_next, dig_st_next, dig_s_next;
  logic [PW-1:0] presc_reg, presc_next;
  logic [AW-1:0] alarm_cnt_reg, alarm_cnt_next;
  logic [BW-1:0] bz_cnt_reg, bz_cnt_next;
  logic          bz_phase_reg, bz_phase_next;
  logic [7:0]    led_reg, led_next;
  logic          bz_reg, bz_next;

  logic       tick, nonzero, enter_run, enter_alarm, rotate;
  logic       do_clear, do_stop, do_start, do_load;
  logic [3:0] preset, dec_m, dec_st, dec_s;
  logic       dec_zero;

  always_comb begin
    state_next     = state_reg;
    dig_m_next     = dig_m_reg;
    dig_st_next    = dig_st_reg;
    dig_s_next     = dig_s_reg;
    alarm_cnt_next = alarm_cnt_reg;
    bz_cnt_next    = bz_cnt_reg;
    bz_phase_next  = bz_phase_reg;
    led_next       = 8'h00;
    bz_next        = 1'b0;
    enter_run      = 1'b0;
    enter_alarm    = 1'b0;
    rotate         = 1'b0;

    tick       = (presc_reg == PRESC_MAX);
    presc_next = tick ? '0 : presc_reg + 1'b1;
    preset     = (RSW > 4'd9) ? 4'd9 : RSW;
    nonzero    = |{dig_m_reg, dig_st_reg, dig_s_reg};

    // Only the highest-priority press of the cycle is acted on.
    do_clear = press_reg[3];
    do_stop  = !press_reg[3] && press_reg[2];
    do_start = (press_reg[3:2] == 2'b00) && press_reg[0];
    do_load  = (press_reg[3:2] == 2'b00) && !press_reg[0] && press_reg[1];

    // One-second BCD decrement with borrow through ST into M.
    dec_m  = dig_m_reg;
    dec_st = dig_st_reg;
    dec_s  = dig_s_reg - 4'd1;
    if (dig_s_reg == 4'd0) begin
      dec_s = 4'd9;
      if (dig_st_reg != 4'd0) begin
        dec_st = dig_st_reg - 4'd1;
      end else begin
        dec_st = 4'd5;
        dec_m  = dig_m_reg - 4'd1;
      end
    end
    dec_zero = (dec_m == 4'd0) && (dec_st == 4'd0) && (dec_s == 4'd0);

    case (state_reg)
      S_IDLE: begin
        if (do_clear) begin
          {dig_m_next, dig_st_next, dig_s_next} = 12'h000;
        end else if (do_start && nonzero) begin
          enter_run = 1'b1;
        end else if (do_load) begin
          {dig_m_next, dig_st_next, dig_s_next} = {preset, 8'h00};
        end
      end
      S_RUN: begin
        // Reaching 0:00 takes precedence over any press in the same cycle.
        if (tick && dec_zero) begin
          {dig_m_next, dig_st_next, dig_s_next} = 12'h000;
          enter_alarm = 1'b1;
        end else if (do_clear) begin
          state_next = S_IDLE;
          {dig_m_next, dig_st_next, dig_s_next} = 12'h000;
        end else if (do_start) begin
          state_next = S_PAUSE;
        end else if (tick) begin
          {dig_m_next, dig_st_next, dig_s_next} = {dec_m, dec_st, dec_s};
          rotate = 1'b1;
        end
      end
      S_PAUSE: begin
        if (do_clear) begin
          state_next = S_IDLE;
          {dig_m_next, dig_st_next, dig_s_next} = 12'h000;
        end else if (do_start && nonzero) begin
          enter_run = 1'b1;
        end else if (do_load) begin
          {dig_m_next, dig_st_next, dig_s_next} = {preset, 8'h00};
        end
      end
      default: begin
        if (do_clear || do_stop || do_start) begin
          state_next = S_IDLE;
          {dig_m_next, dig_st_next, dig_s_next} = 12'h000;
        end else if (tick) begin
          if (alarm_cnt_reg == ALARM_MAX) begin
            state_next = S_IDLE;
            {dig_m_next, dig_st_next, dig_s_next} = 12'h000;
          end else begin
            alarm_cnt_next = alarm_cnt_reg + 1'b1;
          end
        end
      end
    endcase

    if (enter_run) begin
      state_next = S_RUN;
      presc_next = '0;
    end
    if (enter_alarm) begin
      state_next     = S_ALARM;
      presc_next     = '0;
      alarm_cnt_next = '0;
      bz_cnt_next    = '0;
      bz_phase_next  = 1'b1;
    end else if (state_reg == S_ALARM && state_next == S_ALARM) begin
      if (bz_cnt_reg == BZ_MAX) begin
        bz_cnt_next   = '0;
        bz_phase_next = !bz_phase_reg;
      end else begin
        bz_cnt_next = bz_cnt_reg + 1'b1;
      end
    end

    // LED and BZ are computed from next-state values so the registered
    // outputs line up with the prescaler count they are displayed against.
    case (state_next)
      S_PAUSE: led_next = 8'h01;
      S_RUN: begin
        if (enter_run)   led_next = 8'h01;
        else if (rotate) led_next = {led_reg[6:0], led_reg[7]};
        else             led_next = led_reg;
      end
      S_ALARM: begin
        led_next = (presc_next < HALF) ? 8'hFF : 8'h00;
        bz_next  = bz_phase_next && (presc_next < HALF);
      end
      default: led_next = 8'h00;
    endcase
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state_reg     <= S_IDLE;
      psw_s1_reg    <= 4'h0;
      psw_s2_reg    <= 4'h0;
      psw_prev_reg  <= 4'h0;
      press_reg     <= 4'h0;
      dig_m_reg     <= 4'h0;
      dig_st_reg    <= 4'h0;
      dig_s_reg     <= 4'h0;
      presc_reg     <= '0;
      alarm_cnt_reg <= '0;
      bz_cnt_reg    <= '0;
      bz_phase_reg  <= 1'b0;
      led_reg       <= 8'h00;
      bz_reg        <= 1'b0;
    end else begin
      psw_s1_reg    <= PSW;
      psw_s2_reg    <= psw_s1_reg;
      psw_prev_reg  <= psw_s2_reg;
      press_reg     <= psw_s2_reg & ~psw_prev_reg;
      state_reg     <= state_next;
      dig_m_reg     <= dig_m_next;
      dig_st_reg    <= dig_st_next;
      dig_s_reg     <= dig_s_next;
      presc_reg     <= presc_next;
      alarm_cnt_reg <= alarm_cnt_next;
      bz_cnt_reg    <= bz_cnt_next;
      bz_phase_reg  <= bz_phase_next;
      led_reg       <= led_next;
      bz_reg        <= bz_next;
    end
  end

  assign STATE  = state_reg;
  assign DIG_M  = dig_m_reg;
  assign DIG_ST = dig_st_reg;
  assign DIG_S  = dig_s_reg;
  assign LED    = led_reg;
  assign BZ     = bz_reg;

endmodule

// File: tb/tb_kitchen_timer_ctrl.sv
// Testbench for kitchen_timer_ctrl with TICK_DIV=4, BZ_DIV=1, ALARM_SEC=3.
// Expected snapshots {STATE, DIG_M, DIG_ST, DIG_S, LED, BZ} are queued when
// stimulus is applied and popped and compared once the DUT has responded.
module tb_kitchen_timer_ctrl;

  logic       CLOCK = 1'b0;
  logic       RESET = 1'b1;
  logic [3:0] PSW   = 4'h0;
  logic [3:0] RSW   = 4'h0;
  logic [3:0] DIG_M, DIG_ST, DIG_S;
  logic [7:0] LED;
  logic       BZ;
  logic [1:0] STATE;

  kitchen_timer_ctrl #(.TICK_DIV(4), .BZ_DIV(1), .ALARM_SEC(3)) dut (
    .CLOCK(CLOCK), .RESET(RESET), .PSW(PSW), .RSW(RSW),
    .DIG_M(DIG_M), .DIG_ST(DIG_ST), .DIG_S(DIG_S),
    .LED(LED), .BZ(BZ), .STATE(STATE)
  );

  always #5 CLOCK = ~CLOCK;

  string       name_q[$];
  logic [22:0] val_q[$];
  string       nm;
  logic [22:0] ev, got;
  int          checks = 0;
  int          passed = 0;

  function automatic logic [22:0] pack(input logic [1:0] st, input logic [3:0] m,
                                       input logic [3:0] tn, input logic [3:0] s,
                                       input logic [7:0] led, input logic bz);
    return {st, m, tn, s, led, bz};
  endfunction

  // Independent model of the display: plain seconds split into M:SS.
  function automatic logic [22:0] pack_secs(input logic [1:0] st, input int secs,
                                            input logic [7:0] led, input logic bz);
    return pack(st, 4'(secs / 60), 4'((secs % 60) / 10), 4'(secs % 10), led, bz);
  endfunction

  function automatic logic [22:0] snap();
    return {STATE, DIG_M, DIG_ST, DIG_S, LED, BZ};
  endfunction

  task automatic expect_push(input string n, input logic [22:0] v);
    name_q.push_back(n);
    val_q.push_back(v);
  endtask

  // Advance n rising edges, then settle 2 time units past the edge.
  task automatic cyc(input int n);
    repeat (n) @(posedge CLOCK);
    #2;
  endtask

  // Button press: the action lands on the 4th edge after PSW rises.
  task automatic press(input logic [3:0] m);
    PSW = m;
    cyc(4);
    PSW = 4'h0;
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    expect_push("reset", pack(2'd0, 4'd0, 4'd0, 4'd0, 8'h00, 1'b0));
    cyc(2);
    nm = name_q.pop_front(); ev = val_q.pop_front(); got = snap(); checks++;
    if (got !== ev) $display("FAIL %s: got %h need %h", nm, got, ev); else passed++;
    RESET = 1'b0;
    PSW = 4'h1;
    expect_push("start_at_zero", pack(2'd0, 4'd0, 4'd0, 4'd0, 8'h00, 1'b0));
    cyc(10);
    nm = name_q.pop_front(); ev = val_q.pop_front(); got = snap(); checks++;
    if (got !== ev) $display("FAIL %s: got %h need %h", nm, got, ev); else passed++;
    PSW = 4'h0;
    cyc(4);
  endtask

  task automatic test_load_count();
    RSW = 4'd1;
    expect_push("load_1", pack(2'd0, 4'd1, 4'd0, 4'd0, 8'h00, 1'b0));
    press(4'h2);
    nm = name_q.pop_front(); ev = val_q.pop_front(); got = snap(); checks++;
    if (got !== ev) $display("FAIL %s: got %h need %h", nm, got, ev); else passed++;
    expect_push("run_entry", pack(2'd1, 4'd1, 4'd0, 4'd0, 8'h01, 1'b0));
    press(4'h1);
    nm = name_q.pop_front(); ev = val_q.pop_front(); got = snap(); checks++;
    if (got !== ev) $display("FAIL %s: got %h need %h", nm, got, ev); else passed++;
    for (int k = 1; k <= 60; k++) begin
      if (k < 60) expect_push($sformatf("tick%0d", k), pack_secs(2'd1, 60 - k, 8'(1 << (k % 8)), 1'b0));
      else        expect_push("alarm_entry", pack_secs(2'd3, 0, 8'hFF, 1'b1));
      cyc(4);
      nm = name_q.pop_front(); ev = val_q.pop_front(); got = snap(); checks++;
      if (got !== ev) $display("FAIL %s: got %h need %h", nm, got, ev); else passed++;
    end
    // Prescaler phase c%4: LED on while phase<2, buzzer toggles every cycle from 1.
    for (int c = 1; c <= 4; c++) begin
      expect_push($sformatf("alarm_wave%0d", c),
                  pack(2'd3, 4'd0, 4'd0, 4'd0, ((c % 4) < 2) ? 8'hFF : 8'h00,
                       ((c % 4) < 2) && (c % 2 == 0)));
      cyc(1);
      nm = name_q.pop_front(); ev = val_q.pop_front(); got = snap(); checks++;
      if (got !== ev) $display("FAIL %s: got %h need %h", nm, got, ev); else passed++;
    end
  endtask

  task automatic test_alarm_stop();
    expect_push("alarm_stop", pack(2'd0, 4'd0, 4'd0, 4'd0, 8'h00, 1'b0));
    press(4'h4);
    nm = name_q.pop_front(); ev = val_q.pop_front(); got = snap(); checks++;
    if (got !== ev) $display("FAIL %s: got %h need %h", nm, got, ev); else passed++;
  endtask

  task automatic test_alarm_timeout();
    RSW = 4'd1;
    press(4'h2);
    press(4'h1);
    expect_push("alarm_again", pack(2'd3, 4'd0, 4'd0, 4'd0, 8'hFF, 1'b1));
    cyc(240);
    nm = name_q.pop_front(); ev = val_q.pop_front(); got = snap(); checks++;
    if (got !== ev) $display("FAIL %s: got %h need %h", nm, got, ev); else passed++;
    expect_push("alarm_hold", pack(2'd3, 4'd0, 4'd0, 4'd0, 8'h00, 1'b0));
    cyc(11);
    nm = name_q.pop_front(); ev = val_q.pop_front(); got = snap(); checks++;
    if (got !== ev) $display("FAIL %s: got %h need %h", nm, got, ev); else passed++;
    expect_push("alarm_timeout", pack(2'd0, 4'd0, 4'd0, 4'd0, 8'h00, 1'b0));
    cyc(1);
    nm = name_q.pop_front(); ev = val_q.pop_front(); got = snap(); checks++;
    if (got !== ev) $display("FAIL %s: got %h need %h", nm, got, ev); else passed++;
  endtask

  task automatic test_pause();
    RSW = 4'd2;
    expect_push("load_2", pack(2'd0, 4'd2, 4'd0, 4'd0, 8'h00, 1'b0));
    press(4'h2);
    nm = name_q.pop_front(); ev = val_q.pop_front(); got = snap(); checks++;
    if (got !== ev) $display("FAIL %s: got %h need %h", nm, got, ev); else passed++;
    expect_push("run2_entry", pack(2'd1, 4'd2, 4'd0, 4'd0, 8'h01, 1'b0));
    press(4'h1);
    nm = name_q.pop_front(); ev = val_q.pop_front(); got = snap(); checks++;
    if (got !== ev) $display("FAIL %s: got %h need %h", nm, got, ev); else passed++;
    expect_push("run_5_ticks", pack_secs(2'd1, 115, 8'h20, 1'b0));
    cyc(20);
    nm = name_q.pop_front(); ev = val_q.pop_front(); got = snap(); checks++;
    if (got !== ev) $display("FAIL %s: got %h need %h", nm, got, ev); else passed++;
    // This pause press lands on a tick edge: the decrement must be dropped.
    expect_push("pause_on_tick", pack_secs(2'd2, 115, 8'h01, 1'b0));
    press(4'h1);
    nm = name_q.pop_front(); ev = val_q.pop_front(); got = snap(); checks++;
    if (got !== ev) $display("FAIL %s: got %h need %h", nm, got, ev); else passed++;
    for (int i = 0; i < 4; i++) begin
      expect_push($sformatf("pause_hold%0d", i), pack_secs(2'd2, 115, 8'h01, 1'b0));
      cyc(10);
      nm = name_q.pop_front(); ev = val_q.pop_front(); got = snap(); checks++;
      if (got !== ev) $display("FAIL %s: got %h need %h", nm, got, ev); else passed++;
    end
    expect_push("resume", pack_secs(2'd1, 115, 8'h01, 1'b0));
    press(4'h1);
    nm = name_q.pop_front(); ev = val_q.pop_front(); got = snap(); checks++;
    if (got !== ev) $display("FAIL %s: got %h need %h", nm, got, ev); else passed++;
    expect_push("resume_tick", pack_secs(2'd1, 114, 8'h02, 1'b0));
    cyc(4);
    nm = name_q.pop_front(); ev = val_q.pop_front(); got = snap(); checks++;
    if (got !== ev) $display("FAIL %s: got %h need %h", nm, got, ev); else passed++;
  endtask

  task automatic test_priority();
    expect_push("clear_run", pack(2'd0, 4'd0, 4'd0, 4'd0, 8'h00, 1'b0));
    press(4'h8);
    nm = name_q.pop_front(); ev = val_q.pop_front(); got = snap(); checks++;
    if (got !== ev) $display("FAIL %s: got %h need %h", nm, got, ev); else passed++;
    RSW = 4'd12;
    expect_push("load_clamp", pack(2'd0, 4'd9, 4'd0, 4'd0, 8'h00, 1'b0));
    press(4'h2);
    nm = name_q.pop_front(); ev = val_q.pop_front(); got = snap(); checks++;
    if (got !== ev) $display("FAIL %s: got %h need %h", nm, got, ev); else passed++;
    expect_push("clear_beats_start", pack(2'd0, 4'd0, 4'd0, 4'd0, 8'h00, 1'b0));
    press(4'h9);
    nm = name_q.pop_front(); ev = val_q.pop_front(); got = snap(); checks++;
    if (got !== ev) $display("FAIL %s: got %h need %h", nm, got, ev); else passed++;
  endtask

  task automatic test_async_reset();
    RSW = 4'd3;
    press(4'h2);
    expect_push("run3_entry", pack(2'd1, 4'd3, 4'd0, 4'd0, 8'h01, 1'b0));
    press(4'h1);
    nm = name_q.pop_front(); ev = val_q.pop_front(); got = snap(); checks++;
    if (got !== ev) $display("FAIL %s: got %h need %h", nm, got, ev); else passed++;
    expect_push("run3_tick", pack_secs(2'd1, 179, 8'h02, 1'b0));
    cyc(6);
    nm = name_q.pop_front(); ev = val_q.pop_front(); got = snap(); checks++;
    if (got !== ev) $display("FAIL %s: got %h need %h", nm, got, ev); else passed++;
    // Assert reset mid-cycle and sample before the next clock edge.
    expect_push("async_reset", pack(2'd0, 4'd0, 4'd0, 4'd0, 8'h00, 1'b0));
    #2;
    RESET = 1'b1;
    #1;
    nm = name_q.pop_front(); ev = val_q.pop_front(); got = snap(); checks++;
    if (got !== ev) $display("FAIL %s: got %h need %h", nm, got, ev); else passed++;
    @(negedge CLOCK);
    RESET = 1'b0;
    expect_push("after_reset", pack(2'd0, 4'd0, 4'd0, 4'd0, 8'h00, 1'b0));
    cyc(8);
    nm = name_q.pop_front(); ev = val_q.pop_front(); got = snap(); checks++;
    if (got !== ev) $display("FAIL %s: got %h need %h", nm, got, ev); else passed++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, need finish earlier", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_load_count();
    test_alarm_stop();
    test_alarm_timeout();
    test_pause();
    test_priority();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
